// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the mem_req/mem_rdata protocol
// Provides default bus widths, the request opcode enum and the read-latency ceiling.
package mem_pkg;
    localparam int MEM_AW_DEF   = 16;
    localparam int MEM_DW_DEF   = 32;
    localparam int MAX_READ_LAT = 8;
    typedef enum logic {MEM_RD = 1'b0, MEM_WR = 1'b1} mem_op_e;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: single-channel request bus with in-order read responses
// master: drives mem_req/mem_write/mem_addr/mem_wdata, receives mem_rdata_vld/mem_rdata
// slave:  the responder side of the same signals
interface mem_responder_if import mem_pkg::*; #(
    parameter int AW = MEM_AW_DEF,
    parameter int DW = MEM_DW_DEF
);
    logic          mem_req;
    logic          mem_write;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rdata_vld;
    logic [DW-1:0] mem_rdata;
    modport master (output mem_req, mem_write, mem_addr, mem_wdata, input mem_rdata_vld, mem_rdata);
    modport slave (input mem_req, mem_write, mem_addr, mem_wdata, output mem_rdata_vld, mem_rdata);
endinterface

// File: rtl/mem_rd_pipe.sv
// mem_rd_pipe: LAT-stage valid/data delay line with synchronous clear
// clk, rst      : clock, synchronous active-high clear of all stages
// in_vld/in_data: entry of the delay line
// out_vld/out_data: exit; out_data holds its last valid value between pulses
module mem_rd_pipe import mem_pkg::*; #(
    parameter int LAT = 1,
    parameter int DW  = MEM_DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    input  logic [DW-1:0] in_data,
    output logic          out_vld,
    output logic [DW-1:0] out_data
);
    if (LAT == 0) begin : g_thru
        assign out_vld  = in_vld;
        assign out_data = in_data;
    end else begin : g_dly
        logic [LAT-1:0] vld;
        logic [DW-1:0]  dat [LAT];
        // data stages only load on a valid so the output holds between pulses
        always_ff @(posedge clk)
            if (rst) begin
                vld <= '0;
                for (int i = 0; i < LAT; i++) dat[i] <= '0;
            end else begin
                vld[0] <= in_vld;
                if (in_vld) dat[0] <= in_data;
                for (int i = 1; i < LAT; i++) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) dat[i] <= dat[i-1];
                end
            end
        assign out_vld  = vld[LAT-1];
        assign out_data = dat[LAT-1];
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM answering mem_req with fixed-latency in-order reads
// clk, rst           : clock, synchronous active-high reset (RAM contents survive)
// bus                : protocol slave port (request in, read data/valid out)
// ld_en/ld_write/ld_addr/ld_wdata/ld_rdata : priority backdoor write/peek
// oor_err            : sticky out-of-range request flag
// rd_count/wr_count  : accepted protocol reads/writes, wrapping
module mem_responder import mem_pkg::*; #(
    parameter int MEM_AW   = MEM_AW_DEF,
    parameter int MEM_DW   = MEM_DW_DEF,
    parameter int DEPTH_AW = 10,
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    mem_responder_if.slave      bus,
    input  logic                ld_en,
    input  logic                ld_write,
    input  logic [DEPTH_AW-1:0] ld_addr,
    input  logic [MEM_DW-1:0]   ld_wdata,
    output logic [MEM_DW-1:0]   ld_rdata,
    output logic                oor_err,
    output logic [CNT_W-1:0]    rd_count,
    output logic [CNT_W-1:0]    wr_count
);
    logic [MEM_DW-1:0]   ram [2**DEPTH_AW];
    logic                acc, is_wr, oor, rd_vld;
    logic [DEPTH_AW-1:0] idx;
    logic [MEM_DW-1:0]   rd_data;

    // the backdoor owns the cycle whenever ld_en is high
    assign acc   = bus.mem_req && !ld_en;
    assign is_wr = mem_op_e'(bus.mem_write) == MEM_WR;
    assign oor   = |bus.mem_addr[MEM_AW-1:DEPTH_AW];
    assign idx   = bus.mem_addr[DEPTH_AW-1:0];

    always_ff @(posedge clk)
        if (ld_en && ld_write) ram[ld_addr] <= ld_wdata;
        else if (acc && is_wr && !oor) ram[idx] <= bus.mem_wdata;

    // first read stage is the registered array read; the rest is the delay line
    always_ff @(posedge clk)
        if (rst) begin
            rd_vld   <= 1'b0;
            rd_data  <= '0;
            ld_rdata <= '0;
            oor_err  <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            rd_vld <= acc && !is_wr;
            if (acc && !is_wr) rd_data <= oor ? '0 : ram[idx];
            if (ld_en && !ld_write) ld_rdata <= ram[ld_addr];
            if (acc && oor) oor_err <= 1'b1;
            if (acc && !is_wr) rd_count <= rd_count + CNT_W'(1);
            if (acc && is_wr) wr_count <= wr_count + CNT_W'(1);
        end

    mem_rd_pipe #(.LAT(READ_LAT - 1), .DW(MEM_DW)) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (rd_vld),
        .in_data (rd_data),
        .out_vld (bus.mem_rdata_vld),
        .out_data(bus.mem_rdata)
    );

    always_ff @(posedge clk)
        if (!rst) begin
            assert (READ_LAT >= 1 && READ_LAT <= MAX_READ_LAT)
                else $error("READ_LAT out of range");
            assert (!(bus.mem_req && ld_en))
                else $warning("mem_req ignored while ld_en is high");
        end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized checks of mem_responder against a queue-based reference model
module tb_mem_responder;
    localparam int AW = 16, DW = 32, DAW = 10, N = 3;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
    } pulse_t;

    logic clk = 1'b0, rst = 1'b1;
    logic req = 1'b0, wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic ld_en = 1'b0, ld_wr = 1'b0;
    logic [DAW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic [DW-1:0] ld_rdata [N];
    logic oor [N];
    logic [31:0] rc [N], wc [N];
    logic [3:0] rc1, wc1;
    logic vld [N];
    logic [DW-1:0] rdat [N];

    int lat_of [N] = '{2, 1, 8};
    logic [31:0] msk [N] = '{32'hFFFF_FFFF, 32'h0000_000F, 32'hFFFF_FFFF};

    pulse_t got [N][$];
    pulse_t exp [N][$];
    logic [DW-1:0] mm [1 << DAW];
    int nrd = 0, nwr = 0, cyc = 0, total = 0, bad = 0;
    bit oor_m = 1'b0;

    mem_responder_if #(.AW(AW), .DW(DW)) b0(), b1(), b2();

    assign b0.mem_req = req;   assign b1.mem_req = req;   assign b2.mem_req = req;
    assign b0.mem_write = wr;  assign b1.mem_write = wr;  assign b2.mem_write = wr;
    assign b0.mem_addr = addr; assign b1.mem_addr = addr; assign b2.mem_addr = addr;
    assign b0.mem_wdata = wdata; assign b1.mem_wdata = wdata; assign b2.mem_wdata = wdata;
    assign vld[0] = b0.mem_rdata_vld; assign rdat[0] = b0.mem_rdata;
    assign vld[1] = b1.mem_rdata_vld; assign rdat[1] = b1.mem_rdata;
    assign vld[2] = b2.mem_rdata_vld; assign rdat[2] = b2.mem_rdata;
    assign rc[1] = {28'd0, rc1};
    assign wc[1] = {28'd0, wc1};

    mem_responder #(.READ_LAT(2)) d0 (
        .clk(clk), .rst(rst), .bus(b0), .ld_en(ld_en), .ld_write(ld_wr), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_rdata(ld_rdata[0]), .oor_err(oor[0]), .rd_count(rc[0]), .wr_count(wc[0]));
    mem_responder #(.READ_LAT(1), .CNT_W(4)) d1 (
        .clk(clk), .rst(rst), .bus(b1), .ld_en(ld_en), .ld_write(ld_wr), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_rdata(ld_rdata[1]), .oor_err(oor[1]), .rd_count(rc1), .wr_count(wc1));
    mem_responder #(.READ_LAT(8)) d2 (
        .clk(clk), .rst(rst), .bus(b2), .ld_en(ld_en), .ld_write(ld_wr), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_rdata(ld_rdata[2]), .oor_err(oor[2]), .rd_count(rc[2]), .wr_count(wc[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk)
        for (int i = 0; i < N; i++)
            if (vld[i] === 1'b1) got[i].push_back(pulse_t'{cyc, rdat[i]});

    // one bus cycle; the model applies the protocol rules to the request it issues
    task automatic drive(input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit le = 1'b0, input bit lw = 1'b0,
                         input logic [DAW-1:0] la = '0, input logic [DW-1:0] ldd = '0);
        bit in_rng;
        @(negedge clk); #1;
        req = r; wr = w; addr = a; wdata = d;
        ld_en = le; ld_wr = lw; ld_addr = la; ld_wdata = ldd;
        in_rng = int'(a) < (1 << DAW);
        if (le) begin
            if (lw) mm[la] = ldd;
        end else if (r) begin
            if (!in_rng) oor_m = 1'b1;
            if (w) begin
                nwr++;
                if (in_rng) mm[a[DAW-1:0]] = d;
            end else begin
                nrd++;
                for (int i = 0; i < N; i++)
                    exp[i].push_back(pulse_t'{cyc + lat_of[i], in_rng ? mm[a[DAW-1:0]] : '0});
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, '0, '0);
    endtask

    // reads still in flight when reset takes effect are never returned
    task automatic do_reset(input int n);
        @(negedge clk); #1;
        rst = 1'b1; req = 1'b0; ld_en = 1'b0;
        for (int i = 0; i < N; i++)
            while (exp[i].size() > 0 && exp[i][$].cyc > cyc) void'(exp[i].pop_back());
        nrd = 0; nwr = 0; oor_m = 1'b0;
        repeat (n) @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            got[i].delete();
            exp[i].delete();
        end
    endtask

    task automatic test_reset();
        do_reset(3);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            total += 6;
            if (vld[i] !== 1'b0) begin bad++; $display("FAIL reset_vld dut%0d got %b want 0", i, vld[i]); end
            if (rdat[i] !== '0) begin bad++; $display("FAIL reset_rdata dut%0d got %h want 0", i, rdat[i]); end
            if (ld_rdata[i] !== '0) begin bad++; $display("FAIL reset_ld_rdata dut%0d got %h want 0", i, ld_rdata[i]); end
            if (oor[i] !== 1'b0) begin bad++; $display("FAIL reset_oor dut%0d got %b want 0", i, oor[i]); end
            if (rc[i] !== '0) begin bad++; $display("FAIL reset_rd_count dut%0d got %0d want 0", i, rc[i]); end
            if (wc[i] !== '0) begin bad++; $display("FAIL reset_wr_count dut%0d got %0d want 0", i, wc[i]); end
        end
    endtask

    task automatic test_preload_burst();
        clear_q();
        for (int a = 0; a < 16; a++) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, DAW'(a), DW'(a + 1));
        for (int a = 0; a < 16; a++) drive(1'b1, 1'b0, AW'(a), '0);
        idle(12);
        for (int i = 0; i < N; i++) begin
            total += 2;
            if (got[i].size() != exp[i].size()) begin bad++; $display("FAIL burst_count dut%0d got %0d want %0d", i, got[i].size(), exp[i].size()); end
            else foreach (got[i][k]) begin
                total++;
                if (got[i][k].cyc != exp[i][k].cyc || got[i][k].d !== exp[i][k].d) begin
                    bad++; $display("FAIL burst_data dut%0d #%0d got cyc %0d %h want cyc %0d %h", i, k, got[i][k].cyc, got[i][k].d, exp[i][k].cyc, exp[i][k].d);
                end
            end
            if (rc[i] !== (32'(nrd) & msk[i])) begin bad++; $display("FAIL burst_rd_count dut%0d got %0d want %0d", i, rc[i], 32'(nrd) & msk[i]); end
        end
    endtask

    task automatic test_raw();
        clear_q();
        drive(1'b1, 1'b1, 16'd5, 32'hDEAD_BEEF);
        drive(1'b1, 1'b0, 16'd5, '0);
        idle(12);
        for (int i = 0; i < N; i++) begin
            total += 2;
            if (got[i].size() != 1 || got[i][0].d !== 32'hDEAD_BEEF || got[i][0].cyc != exp[i][0].cyc) begin
                bad++; $display("FAIL raw_data dut%0d pulses %0d first %h want one pulse DEADBEEF at cyc %0d", i, got[i].size(), got[i].size() ? got[i][0].d : '0, exp[i][0].cyc);
            end
            if (wc[i] !== (32'(nwr) & msk[i])) begin bad++; $display("FAIL raw_wr_count dut%0d got %0d want %0d", i, wc[i], 32'(nwr) & msk[i]); end
        end
    endtask

    task automatic test_oor();
        clear_q();
        drive(1'b1, 1'b0, 16'h0400, '0);
        drive(1'b1, 1'b1, 16'h8005, 32'h1234_5678);
        drive(1'b1, 1'b0, 16'd5, '0);
        drive(1'b1, 1'b0, 16'd3, '0);
        idle(12);
        for (int i = 0; i < N; i++) begin
            total += 2;
            if (got[i].size() != exp[i].size()) begin bad++; $display("FAIL oor_count dut%0d got %0d want %0d", i, got[i].size(), exp[i].size()); end
            else foreach (got[i][k]) begin
                total++;
                if (got[i][k].cyc != exp[i][k].cyc || got[i][k].d !== exp[i][k].d) begin
                    bad++; $display("FAIL oor_data dut%0d #%0d got cyc %0d %h want cyc %0d %h", i, k, got[i][k].cyc, got[i][k].d, exp[i][k].cyc, exp[i][k].d);
                end
            end
            if (oor[i] !== oor_m) begin bad++; $display("FAIL oor_flag dut%0d got %b want %b", i, oor[i], oor_m); end
        end
        idle(5);
        for (int i = 0; i < N; i++) begin
            total++;
            if (oor[i] !== 1'b1) begin bad++; $display("FAIL oor_sticky dut%0d got %b want 1", i, oor[i]); end
        end
    endtask

    task automatic test_flush();
        clear_q();
        for (int a = 0; a < 3; a++) drive(1'b1, 1'b0, AW'(a), '0);
        do_reset(2);
        idle(12);
        for (int i = 0; i < N; i++) begin
            total += 4;
            if (got[i].size() != exp[i].size()) begin bad++; $display("FAIL flush_count dut%0d got %0d want %0d", i, got[i].size(), exp[i].size()); end
            else foreach (got[i][k]) begin
                total++;
                if (got[i][k].cyc != exp[i][k].cyc || got[i][k].d !== exp[i][k].d) begin
                    bad++; $display("FAIL flush_data dut%0d #%0d got cyc %0d %h want cyc %0d %h", i, k, got[i][k].cyc, got[i][k].d, exp[i][k].cyc, exp[i][k].d);
                end
            end
            if (rc[i] !== '0) begin bad++; $display("FAIL flush_rd_count dut%0d got %0d want 0", i, rc[i]); end
            if (wc[i] !== '0) begin bad++; $display("FAIL flush_wr_count dut%0d got %0d want 0", i, wc[i]); end
            if (oor[i] !== 1'b0) begin bad++; $display("FAIL flush_oor dut%0d got %b want 0", i, oor[i]); end
        end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd5);
        idle(1);
        for (int i = 0; i < N; i++) begin
            total++;
            if (ld_rdata[i] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL flush_peek5 dut%0d got %h want deadbeef", i, ld_rdata[i]); end
        end
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'd0);
        idle(1);
        for (int i = 0; i < N; i++) begin
            total++;
            if (ld_rdata[i] !== 32'h1) begin bad++; $display("FAIL flush_peek0 dut%0d got %h want 1", i, ld_rdata[i]); end
        end
    endtask

    // alternating read/write stream; also the window where the 4-bit counters wrap
    task automatic test_alternate();
        for (int a = 0; a < 32; a++) drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, DAW'(a), DW'($urandom));
        clear_q();
        for (int k = 0; k < 64; k++) drive(1'b1, k[0], AW'($urandom_range(0, 31)), DW'($urandom));
        idle(12);
        for (int i = 0; i < N; i++) begin
            total += 3;
            if (got[i].size() != 32) begin bad++; $display("FAIL alt_vld_count dut%0d got %0d want 32", i, got[i].size()); end
            else foreach (got[i][k]) begin
                total++;
                if (got[i][k].cyc != exp[i][k].cyc || got[i][k].d !== exp[i][k].d) begin
                    bad++; $display("FAIL alt_data dut%0d #%0d got cyc %0d %h want cyc %0d %h", i, k, got[i][k].cyc, got[i][k].d, exp[i][k].cyc, exp[i][k].d);
                end
            end
            if (rc[i] !== (32'(nrd) & msk[i])) begin bad++; $display("FAIL alt_rd_count dut%0d got %0d want %0d", i, rc[i], 32'(nrd) & msk[i]); end
            if (wc[i] !== (32'(nwr) & msk[i])) begin bad++; $display("FAIL alt_wr_count dut%0d got %0d want %0d", i, wc[i], 32'(nwr) & msk[i]); end
        end
    endtask

    task automatic test_random();
        clear_q();
        for (int k = 0; k < 200; k++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 15) == 0) ? AW'(16'h0400 | $urandom_range(0, 16'hFBFF)) : AW'($urandom_range(0, 31));
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a, DW'($urandom));
        end
        idle(12);
        for (int i = 0; i < N; i++) begin
            total += 4;
            if (got[i].size() != exp[i].size()) begin bad++; $display("FAIL rand_count dut%0d got %0d want %0d", i, got[i].size(), exp[i].size()); end
            else foreach (got[i][k]) begin
                total++;
                if (got[i][k].cyc != exp[i][k].cyc || got[i][k].d !== exp[i][k].d) begin
                    bad++; $display("FAIL rand_data dut%0d #%0d got cyc %0d %h want cyc %0d %h", i, k, got[i][k].cyc, got[i][k].d, exp[i][k].cyc, exp[i][k].d);
                end
            end
            if (rc[i] !== (32'(nrd) & msk[i])) begin bad++; $display("FAIL rand_rd_count dut%0d got %0d want %0d", i, rc[i], 32'(nrd) & msk[i]); end
            if (wc[i] !== (32'(nwr) & msk[i])) begin bad++; $display("FAIL rand_wr_count dut%0d got %0d want %0d", i, wc[i], 32'(nwr) & msk[i]); end
            if (oor[i] !== oor_m) begin bad++; $display("FAIL rand_oor dut%0d got %b want %b", i, oor[i], oor_m); end
        end
    endtask

    task automatic test_ld_priority();
        logic [31:0] wc0 [N];
        logic [31:0] rc0 [N];
        for (int i = 0; i < N; i++) begin wc0[i] = wc[i]; rc0[i] = rc[i]; end
        clear_q();
        drive(1'b1, 1'b1, 16'd3, 32'hBAD0_BAD0, 1'b1, 1'b1, 10'd3, 32'hC0FF_EE00);
        drive(1'b1, 1'b0, 16'd3, '0, 1'b1, 1'b0, 10'd3);
        idle(1);
        for (int i = 0; i < N; i++) begin
            total++;
            if (ld_rdata[i] !== 32'hC0FF_EE00) begin bad++; $display("FAIL prio_peek dut%0d got %h want c0ffee00", i, ld_rdata[i]); end
        end
        idle(12);
        for (int i = 0; i < N; i++) begin
            total += 3;
            if (got[i].size() != 0) begin bad++; $display("FAIL prio_no_resp dut%0d got %0d pulses want 0", i, got[i].size()); end
            if (wc[i] !== wc0[i]) begin bad++; $display("FAIL prio_wr_count dut%0d got %0d want %0d", i, wc[i], wc0[i]); end
            if (rc[i] !== rc0[i]) begin bad++; $display("FAIL prio_rd_count dut%0d got %0d want %0d", i, rc[i], rc0[i]); end
        end
        drive(1'b1, 1'b0, 16'd3, '0);
        idle(12);
        for (int i = 0; i < N; i++) begin
            total++;
            if (got[i].size() != 1 || got[i][0].d !== 32'hC0FF_EE00) begin
                bad++; $display("FAIL prio_readback dut%0d pulses %0d first %h want one pulse c0ffee00", i, got[i].size(), got[i].size() ? got[i][0].d : '0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_preload_burst();
        test_raw();
        test_oor();
        test_flush();
        test_alternate();
        test_random();
        test_ld_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
